// File: rtl/pt2262_pkg.sv
// Shared timing constants, FSM state type and symbol encoding helper for the
// PT2262-compatible serialiser.
package pt2262_pkg;

  localparam int ALPHA_POR_SUBBIT = 16;
  localparam int CURTO_HI         = 4;
  localparam int LONGO_HI         = 12;
  localparam int SYNC_HI          = 4;
  localparam int SYNC_LEN         = 128;

  typedef enum logic [1:0] {IDLE, DATA, SYNC, FIM} estado_t;

  typedef logic [1:0] par_t;

  // Float wins over the value bit; 0 -> 00, 1 -> 11, F -> 01.
  function automatic par_t codifica_simbolo(input logic f, input logic v);
    if (f)      return 2'b01;
    else if (v) return 2'b11;
    else        return 2'b00;
  endfunction

endpackage

// File: rtl/serializador_pt2262_if.sv
// Request/symbol/waveform bundle between the comparator logic and the encoder.
interface serializador_pt2262_if #(
  parameter int N_BITS = 12
);
  import pt2262_pkg::*;

  logic              start;
  logic              stop;
  logic [N_BITS-1:0] sym_f;
  logic [N_BITS-1:0] sym_01;
  logic              dout;
  logic              busy;
  logic              done;

  modport master (output start, stop, sym_f, sym_01,
                  input  dout, busy, done);

  modport slave  (input  start, stop, sym_f, sym_01,
                  output dout, busy, done);

endinterface

// File: rtl/gera_codigo_par.sv
// Expands N_BITS tri-state symbols into the 2*N_BITS code word;
// pair i lands on code[2i+1:2i].
module gera_codigo_par
  import pt2262_pkg::*;
#(
  parameter int N_BITS = 12
) (
  input  logic [N_BITS-1:0]   sym_f,
  input  logic [N_BITS-1:0]   sym_01,
  output logic [2*N_BITS-1:0] code
);

  // Purely combinational per-symbol mapping.
  always_comb begin
    code = '0;
    for (int i = 0; i < N_BITS; i++) begin
      code[2*i +: 2] = codifica_simbolo(sym_f[i], sym_01[i]);
    end
  end

endmodule

// File: rtl/serializador_pt2262.sv
// PT2262 encoder back end: latches the code word on start, then emits
// REPEAT frames of timed data sub-bits plus a sync bit on a registered dout.
module serializador_pt2262
  import pt2262_pkg::*;
#(
  parameter int N_BITS    = 12,
  parameter int ALPHA_DIV = 4,
  parameter int REPEAT    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serializador_pt2262_if.slave   bus
);

  localparam int PW = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;
  localparam int SW = $clog2(2 * N_BITS);

  localparam logic [PW-1:0] PRESC_MAX = PW'(ALPHA_DIV - 1);
  localparam logic [SW-1:0] SUB_MAX   = SW'(2 * N_BITS - 1);
  localparam logic [6:0]    DATA_MAX  = 7'(ALPHA_POR_SUBBIT - 1);
  localparam logic [6:0]    SYNC_MAX  = 7'(SYNC_LEN - 1);
  localparam logic [7:0]    FRAME_MAX = 8'(REPEAT - 1);

  estado_t             state, nxt_state;
  logic [PW-1:0]       presc, nxt_presc;
  logic [6:0]          alpha, nxt_alpha;
  logic [SW-1:0]       sub, nxt_sub;
  logic [7:0]          frame, nxt_frame;
  logic [2*N_BITS-1:0] code_in, code_reg, code_src;
  logic [SW-1:0]       bit_idx;
  logic                stop_flag;
  logic                dout_reg, nxt_dout;
  logic                busy_int;

  gera_codigo_par #(.N_BITS(N_BITS)) u_gera (
    .sym_f  (bus.sym_f),
    .sym_01 (bus.sym_01),
    .code   (code_in)
  );

  assign busy_int = (state == DATA) || (state == SYNC);
  assign bus.busy = busy_int;
  assign bus.done = (state == FIM);
  assign bus.dout = dout_reg;

  // Within a pair the odd (high) bit goes out first, so sub-bit k reads code[k^1].
  assign code_src = (state == IDLE) ? code_in : code_reg;
  assign bit_idx  = nxt_sub ^ SW'(1);

  // Next position in the frame, next state, and the dout level for that position.
  always_comb begin
    nxt_state = state;
    nxt_presc = presc;
    nxt_alpha = alpha;
    nxt_sub   = sub;
    nxt_frame = frame;
    nxt_dout  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_state = DATA;
          nxt_presc = '0;
          nxt_alpha = '0;
          nxt_sub   = '0;
          nxt_frame = '0;
        end
      end
      DATA: begin
        if (presc == PRESC_MAX) begin
          nxt_presc = '0;
          if (alpha == DATA_MAX) begin
            nxt_alpha = '0;
            if (sub == SUB_MAX) begin
              nxt_sub   = '0;
              nxt_state = SYNC;
            end else begin
              nxt_sub = sub + 1'b1;
            end
          end else begin
            nxt_alpha = alpha + 1'b1;
          end
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      SYNC: begin
        if (presc == PRESC_MAX) begin
          nxt_presc = '0;
          if (alpha == SYNC_MAX) begin
            nxt_alpha = '0;
            nxt_frame = frame + 1'b1;
            if ((frame == FRAME_MAX) || stop_flag || bus.stop) begin
              nxt_state = FIM;
            end else begin
              nxt_state = DATA;
              nxt_sub   = '0;
            end
          end else begin
            nxt_alpha = alpha + 1'b1;
          end
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      FIM: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    case (nxt_state)
      DATA:    nxt_dout = (nxt_alpha < (code_src[bit_idx] ? 7'(LONGO_HI) : 7'(CURTO_HI)));
      SYNC:    nxt_dout = (nxt_alpha < 7'(SYNC_HI));
      default: nxt_dout = 1'b0;
    endcase
  end

  // State, timing counters and the registered waveform output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      alpha    <= '0;
      sub      <= '0;
      frame    <= '0;
      dout_reg <= 1'b0;
    end else begin
      state    <= nxt_state;
      presc    <= nxt_presc;
      alpha    <= nxt_alpha;
      sub      <= nxt_sub;
      frame    <= nxt_frame;
      dout_reg <= nxt_dout;
    end
  end

  // Code word is captured once per accepted start so later input changes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg <= '0;
    end else if ((state == IDLE) && bus.start) begin
      code_reg <= code_in;
    end
  end

  // Sticky early-stop request, honoured only at the end of the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_flag <= 1'b0;
    end else if (state == FIM) begin
      stop_flag <= 1'b0;
    end else if (busy_int && bus.stop) begin
      stop_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serializador_pt2262.sv
// Scoreboard bench: the expected per-cycle {dout,busy,done} of every transmission
// is built from the symbols when start is driven, then popped cycle by cycle.
module tb_serializador_pt2262;

  localparam int NB = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic [NB-1:0] sym_f  = '0;
  logic [NB-1:0] sym_01 = '0;
  int            sel    = 0;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];
  logic [2:0] obs;

  serializador_pt2262_if #(.N_BITS(NB)) if_a ();
  serializador_pt2262_if #(.N_BITS(NB)) if_b ();
  serializador_pt2262_if #(.N_BITS(NB)) if_c ();

  serializador_pt2262 #(.N_BITS(NB), .ALPHA_DIV(1), .REPEAT(2)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a));
  serializador_pt2262 #(.N_BITS(NB), .ALPHA_DIV(1), .REPEAT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b));
  serializador_pt2262 #(.N_BITS(NB), .ALPHA_DIV(4), .REPEAT(1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c));

  assign if_a.start  = start && (sel == 0);
  assign if_b.start  = start && (sel == 1);
  assign if_c.start  = start && (sel == 2);
  assign if_a.stop   = stop && (sel == 0);
  assign if_b.stop   = stop && (sel == 1);
  assign if_c.stop   = stop && (sel == 2);
  assign if_a.sym_f  = sym_f;
  assign if_b.sym_f  = sym_f;
  assign if_c.sym_f  = sym_f;
  assign if_a.sym_01 = sym_01;
  assign if_b.sym_01 = sym_01;
  assign if_c.sym_01 = sym_01;

  // Observation port of whichever instance is currently under test.
  always_comb begin
    case (sel)
      1:       obs = {if_b.dout, if_b.busy, if_b.done};
      2:       obs = {if_c.dout, if_c.busy, if_c.done};
      default: obs = {if_a.dout, if_a.busy, if_a.done};
    endcase
  end

  task automatic check_output(input string tag, input logic [2:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed dout/busy/done=%b expected %b", tag, obs, want);
    end
  endtask

  // Reference waveform: per symbol the high code bit first, then sync, then one done cycle.
  task automatic push_frames(input logic [NB-1:0] f, input logic [NB-1:0] v,
                             input int adiv, input int frames);
    for (int fr = 0; fr < frames; fr++) begin
      for (int i = 0; i < NB; i++) begin
        for (int h = 0; h < 2; h++) begin
          logic b;
          int   hi;
          b  = f[i] ? (h == 1) : v[i];
          hi = b ? 12 : 4;
          for (int c = 0; c < 16 * adiv; c++)
            exp_q.push_back({(c < hi * adiv), 1'b1, 1'b0});
        end
      end
      for (int c = 0; c < 128 * adiv; c++)
        exp_q.push_back({(c < 4 * adiv), 1'b1, 1'b0});
    end
    exp_q.push_back(3'b001);
  endtask

  // One transmission on instance 'which'; called #1 after a clock edge with the DUT idle.
  task automatic apply_stimulus(input int which, input logic [NB-1:0] f, input logic [NB-1:0] v,
                                input int adiv, input int frames, input int stop_at,
                                input int start_at, input int change_at, input int rst_at);
    int   n;
    logic aborted;
    sel = which;
    check_output($sformatf("idle_u%0d", which), 3'b000);
    sym_f  = f;
    sym_01 = v;
    start  = 1'b1;
    push_frames(f, v, adiv, frames);
    @(posedge clk); #1;
    start   = 1'b0;
    n       = 1;
    aborted = 1'b0;
    while (exp_q.size() > 0 && !aborted) begin
      logic [2:0] want;
      want = exp_q.pop_front();
      check_output($sformatf("u%0d_cyc%0d", which, n), want);
      start = (n == start_at) || (exp_q.size() == 0);
      stop  = (n == stop_at);
      if (n == change_at) begin
        sym_f  = ~sym_f;
        sym_01 = NB'($urandom);
      end
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check_output($sformatf("u%0d_rst_async", which), 3'b000);
        exp_q.delete();
        aborted = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_output($sformatf("reset_u%0d", s), 3'b000);
    end
    @(posedge clk); #1;

    apply_stimulus(0, 12'h000, 12'h000, 1, 2, -1, -1, -1, -1);
    apply_stimulus(0, 12'h001, 12'hFFE, 1, 2, -1, -1, -1, -1);
    apply_stimulus(0, 12'h001, 12'h001, 1, 2, -1, -1, 300, -1);
    apply_stimulus(1, 12'h0A5, 12'h3C9, 1, 1, 100, 50, -1, -1);
    apply_stimulus(0, 12'h000, 12'hFFF, 1, 2, -1, -1, -1, 200);
    apply_stimulus(0, 12'h0F0, 12'h3C3, 1, 2, -1, -1, -1, -1);
    apply_stimulus(2, 12'h800, 12'h555, 4, 1, -1, -1, -1, -1);
    sel = 2;
    check_output("final_idle", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
